// File: rtl/noc_throttle_pkg.sv
// Shared types and constants for the NoC injection throttle.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   - state encodings exported for monitoring/CSR use
//   - throttle_state_e enum built on those encodings
//   - MILLI_FULL, the nominal full-scale congestion value
//   - sat_milli(), which clamps an out-of-range congestion reading
package noc_throttle_pkg;

  localparam logic [1:0] ST_ENC_NORMAL   = 2'd0;
  localparam logic [1:0] ST_ENC_THROTTLE = 2'd1;
  localparam logic [1:0] ST_ENC_BLOCK    = 2'd2;

  typedef enum logic [1:0] {
    ST_NORMAL   = ST_ENC_NORMAL,
    ST_THROTTLE = ST_ENC_THROTTLE,
    ST_BLOCK    = ST_ENC_BLOCK
  } throttle_state_e;

  localparam logic [15:0] MILLI_FULL = 16'd1000;

  // Readings above full scale behave as fully congested.
  function automatic logic [15:0] sat_milli(input logic [15:0] v);
    return (v > MILLI_FULL) ? MILLI_FULL : v;
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Generic synchronous FIFO with registered storage and full/empty flags.
// Latency: a word written at edge t is visible on rd_dat in the cycle after t.
// Backpressure: writes are dropped while full (a same-cycle read does not free space).
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   wr_vld/wr_dat  write request and data (ignored when full)
//   rd_rdy         read request (ignored when empty)
//   rd_dat         head of the queue (zero after reset)
//   full, empty    occupancy flags
module noc_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = wr_vld && !full;
  assign do_pop  = rd_rdy && !empty;
  assign rd_dat  = mem[rd_ptr];

  // Storage is cleared on reset so the head reads zero until the first write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_push) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/noc_injection_throttle.sv
// Congestion-aware injection regulator between a tile NI and the router local port.
// Latency: flit pushed at edge t is presentable in cycle t+1; congestion reaches state two edges after it changes.
// Backpressure: tile_ready_out = !full; once valid_out_local rises it holds with stable data until ready_in_local.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   tile_flit_in/tile_valid_in   flit from the tile
//   tile_ready_out               FIFO can accept a flit
//   flit_out_local/valid_out_local  flit presented to the router local port
//   ready_in_local               router local-port ready
//   predicted_congestion_milli   router congestion EMA (0..1000 nominal)
//   throttle_state               0 NORMAL, 1 THROTTLE, 2 BLOCK
//   throttled_cycles_count       cycles with a backlog but no valid presented (saturating)
//   flits_injected_count         completed output handshakes (saturating)
module noc_injection_throttle #(
  parameter int FLIT_WIDTH       = 64,
  parameter int FIFO_DEPTH       = 4,
  parameter int THR_LO_MILLI     = 500,
  parameter int THR_HI_MILLI     = 750,
  parameter int BLOCK_MILLI      = 950,
  parameter int TOKEN_PERIOD     = 4,
  parameter int MAX_BLOCK_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [FLIT_WIDTH-1:0] tile_flit_in,
  input  logic                  tile_valid_in,
  output logic                  tile_ready_out,
  output logic [FLIT_WIDTH-1:0] flit_out_local,
  output logic                  valid_out_local,
  input  logic                  ready_in_local,
  input  logic [15:0]           predicted_congestion_milli,
  output logic [1:0]            throttle_state,
  output logic [31:0]           throttled_cycles_count,
  output logic [31:0]           flits_injected_count
);

  import noc_throttle_pkg::*;

  localparam logic [15:0] TH_LO    = 16'(THR_LO_MILLI);
  localparam logic [15:0] TH_HI    = 16'(THR_HI_MILLI);
  localparam logic [15:0] TH_BLOCK = 16'(BLOCK_MILLI);

  localparam int TCW = $clog2(TOKEN_PERIOD + 1);
  localparam logic [TCW-1:0] TOK_LAST = TCW'(TOKEN_PERIOD - 1);

  localparam int SCW = $clog2(MAX_BLOCK_CYCLES + 1);
  localparam logic [SCW-1:0] STARVE_MAX = SCW'(MAX_BLOCK_CYCLES);

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FLIT_WIDTH-1:0] head_dat;
  logic                  push;
  logic                  handshake;

  logic [15:0]           cong_q;
  logic [15:0]           cong_sat;
  throttle_state_e       state_q;
  throttle_state_e       state_d;
  logic                  permit;
  logic                  enter_throttle;
  logic                  token_q;
  logic [TCW-1:0]        tok_cnt_q;
  logic [SCW-1:0]        starve_q;
  logic                  presenting_q;
  logic [31:0]           throttled_q;
  logic [31:0]           injected_q;

  // ---------------------------------------------------------------- buffer
  assign push           = tile_valid_in && !fifo_full;
  assign tile_ready_out = !fifo_full;

  noc_sync_fifo #(
    .WIDTH (FLIT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_vld  (push),
    .wr_dat  (tile_flit_in),
    .rd_rdy  (handshake),
    .rd_dat  (head_dat),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // presenting_q keeps valid up across permit loss or state changes.
  assign valid_out_local = !fifo_empty && (permit || presenting_q);
  assign flit_out_local  = head_dat;
  assign handshake       = valid_out_local && ready_in_local;
  assign throttle_state  = state_q;

  // ------------------------------------------------------------ congestion
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cong_q <= '0;
    end else begin
      cong_q <= predicted_congestion_milli;
    end
  end

  assign cong_sat = sat_milli(cong_q);

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_NORMAL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    permit  = 1'b0;
    case (state_q)
      ST_NORMAL: begin
        permit = 1'b1;
        if (cong_sat >= TH_BLOCK) begin
          state_d = ST_BLOCK;
        end else if (cong_sat >= TH_HI) begin
          state_d = ST_THROTTLE;
        end
      end
      ST_THROTTLE: begin
        permit = token_q;
        if (cong_sat >= TH_BLOCK) begin
          state_d = ST_BLOCK;
        end else if (cong_sat < TH_LO) begin
          state_d = ST_NORMAL;
        end
      end
      ST_BLOCK: begin
        permit = (starve_q == STARVE_MAX);
        if (cong_sat < TH_LO) begin
          state_d = ST_NORMAL;
        end else if (cong_sat < TH_HI) begin
          state_d = ST_THROTTLE;
        end
      end
      default: begin
        state_d = ST_NORMAL;
      end
    endcase
  end

  assign enter_throttle = (state_d == ST_THROTTLE) && (state_q != ST_THROTTLE);

  // ----------------------------------------------------------------- token
  // The handshake cycle counts as the first cycle of the next period, which
  // makes the steady-state spacing exactly TOKEN_PERIOD cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      token_q   <= 1'b0;
      tok_cnt_q <= '0;
    end else if (enter_throttle) begin
      token_q   <= 1'b0;
      tok_cnt_q <= '0;
    end else if (handshake) begin
      token_q   <= (TOKEN_PERIOD == 1);
      tok_cnt_q <= TCW'(1);
    end else if (!token_q) begin
      if (tok_cnt_q >= TOK_LAST) begin
        token_q   <= 1'b1;
        tok_cnt_q <= '0;
      end else begin
        tok_cnt_q <= tok_cnt_q + 1'b1;
      end
    end
  end

  // ------------------------------------------------------ starvation guard
  // Holds at the limit so permit stays granted until a handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_q <= '0;
    end else if (handshake || (state_q != ST_BLOCK) || (state_d != ST_BLOCK)) begin
      starve_q <= '0;
    end else if (!fifo_empty && (starve_q != STARVE_MAX)) begin
      starve_q <= starve_q + 1'b1;
    end
  end

  // ------------------------------------------------------------ presenting
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presenting_q <= 1'b0;
    end else if (handshake) begin
      presenting_q <= 1'b0;
    end else if (valid_out_local) begin
      presenting_q <= 1'b1;
    end
  end

  // -------------------------------------------------------------- counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      throttled_q <= '0;
      injected_q  <= '0;
    end else begin
      if (!fifo_empty && !valid_out_local && (throttled_q != 32'hFFFF_FFFF)) begin
        throttled_q <= throttled_q + 32'd1;
      end
      if (handshake && (injected_q != 32'hFFFF_FFFF)) begin
        injected_q <= injected_q + 32'd1;
      end
    end
  end

  assign throttled_cycles_count = throttled_q;
  assign flits_injected_count   = injected_q;

endmodule

// File: tb/tb_noc_injection_throttle.sv
module tb_noc_injection_throttle;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [63:0] tile_flit_in;
  logic        tile_valid_in;
  logic        tile_ready_out;
  logic [63:0] flit_out_local;
  logic        valid_out_local;
  logic        ready_in_local;
  logic [15:0] predicted_congestion_milli;
  logic [1:0]  throttle_state;
  logic [31:0] throttled_cycles_count;
  logic [31:0] flits_injected_count;

  noc_injection_throttle dut (
    .clk                        (clk),
    .reset_n                    (reset_n),
    .tile_flit_in               (tile_flit_in),
    .tile_valid_in              (tile_valid_in),
    .tile_ready_out             (tile_ready_out),
    .flit_out_local             (flit_out_local),
    .valid_out_local            (valid_out_local),
    .ready_in_local             (ready_in_local),
    .predicted_congestion_milli (predicted_congestion_milli),
    .throttle_state             (throttle_state),
    .throttled_cycles_count     (throttled_cycles_count),
    .flits_injected_count       (flits_injected_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_push_cyc = 0;

  logic [63:0] exp_q[$];
  int          hs_cyc_q[$];
  logic        mon_wait = 1'b0;
  logic [63:0] mon_dat  = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard monitor: every output handshake is compared with the oldest
  // accepted tile flit; a held valid must keep valid and data stable.
  always @(negedge clk) begin
    if (!reset_n) begin
      mon_wait = 1'b0;
    end else begin
      if (mon_wait) begin
        check("hold_valid", valid_out_local, 1'b1);
        check("hold_data", flit_out_local, mon_dat);
      end
      if (valid_out_local && ready_in_local) begin
        hs_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_extra_flit: got %0h required no flit", flit_out_local);
        end else begin
          check("sb_data", flit_out_local, exp_q.pop_front());
        end
      end
      mon_wait = valid_out_local && !ready_in_local;
      mon_dat  = flit_out_local;
    end
  end

  // One clock cycle of tile stimulus; called at posedge+1, returns at posedge+1.
  task automatic tile_cycle(input logic vld, input logic [63:0] d, output logic acc);
    tile_valid_in = vld;
    tile_flit_in  = d;
    @(negedge clk);
    acc = vld && tile_ready_out;
    if (acc) begin
      exp_q.push_back(d);
      last_push_cyc = cyc;
    end
    @(posedge clk);
    #1;
    tile_valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) tile_cycle(1'b0, 64'd0, acc);
  endtask

  task automatic push_flit(input logic [63:0] d);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) tile_cycle(1'b1, d, acc);
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: flit %0h not accepted within 50 cycles", d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc;
    logic [63:0] d;
    int          p, w, cnt, prev;
    logic [31:0] s0, s1;

    // ---------------- reset with random inputs
    reset_n = 1'b0;
    tile_valid_in = 1'b0;
    tile_flit_in = '0;
    ready_in_local = 1'b0;
    predicted_congestion_milli = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      tile_valid_in = 1'($urandom_range(0, 1));
      tile_flit_in = {$urandom, $urandom};
      ready_in_local = 1'($urandom_range(0, 1));
      predicted_congestion_milli = 16'($urandom_range(0, 1100));
      #2;
      check("rst_tile_ready", tile_ready_out, 1'b1);
      check("rst_valid", valid_out_local, 1'b0);
      check("rst_flit", flit_out_local, 64'd0);
      check("rst_state", throttle_state, 2'd0);
      check("rst_throttled", throttled_cycles_count, 32'd0);
      check("rst_injected", flits_injected_count, 32'd0);
    end
    @(posedge clk);
    #1;
    tile_valid_in = 1'b0;
    ready_in_local = 1'b1;
    predicted_congestion_milli = 16'd200;
    reset_n = 1'b1;
    idle(3);

    // ---------------- NORMAL streaming, 20 flits
    hs_cyc_q.delete();
    p = 0;
    for (int i = 0; i < 20; i++) begin
      push_flit(64'hA5A5_0000_0000_0000 + 64'(i));
      if (i == 0) p = last_push_cyc;
    end
    idle(4);
    check("stream_hs_count", hs_cyc_q.size(), 20);
    if (hs_cyc_q.size() > 0) check("stream_first_latency", hs_cyc_q[0], p + 1);
    check("stream_injected", flits_injected_count, 32'd20);
    check("stream_sb_empty", exp_q.size(), 0);

    // ---------------- hysteresis
    predicted_congestion_milli = 16'd800;
    idle(1);
    check("hyst_800_edge1", throttle_state, 2'd0);
    idle(1);
    check("hyst_800_edge2", throttle_state, 2'd1);
    predicted_congestion_milli = 16'd600;
    idle(4);
    check("hyst_600_hold", throttle_state, 2'd1);
    predicted_congestion_milli = 16'd400;
    idle(1);
    check("hyst_400_edge1", throttle_state, 2'd1);
    idle(1);
    check("hyst_400_edge2", throttle_state, 2'd0);

    // ---------------- THROTTLE rate with backlog
    predicted_congestion_milli = 16'd800;
    idle(2);
    check("thr_state", throttle_state, 2'd1);
    hs_cyc_q.delete();
    d = 64'hBEEF_0000_0000_0000;
    for (int i = 0; i < 12; i++) begin
      tile_cycle(1'b1, d, acc);
      if (acc) d = d + 64'd1;
    end
    w = cyc;
    s0 = throttled_cycles_count;
    for (int i = 0; i < 40; i++) begin
      tile_cycle(1'b1, d, acc);
      if (acc) d = d + 64'd1;
    end
    s1 = throttled_cycles_count;
    cnt = 0;
    prev = -1;
    foreach (hs_cyc_q[k]) begin
      if (hs_cyc_q[k] >= w && hs_cyc_q[k] < w + 40) begin
        if (prev >= 0) check("thr_interval", hs_cyc_q[k] - prev, 4);
        prev = hs_cyc_q[k];
        cnt++;
      end
    end
    check("thr_hs_in_40", cnt, 10);
    check("thr_throttled_delta", s1 - s0, 32'd30);
    predicted_congestion_milli = 16'd200;
    idle(10);
    check("thr_drain_sb_empty", exp_q.size(), 0);

    // ---------------- BLOCK starvation guard
    predicted_congestion_milli = 16'd990;
    idle(2);
    check("blk_state", throttle_state, 2'd2);
    hs_cyc_q.delete();
    push_flit(64'hC0DE_0000_0000_0001);
    p = last_push_cyc;
    push_flit(64'hC0DE_0000_0000_0002);
    push_flit(64'hC0DE_0000_0000_0003);
    for (int i = 0; i < 300 && hs_cyc_q.size() < 3; i++) idle(1);
    check("blk_hs_count", hs_cyc_q.size(), 3);
    if (hs_cyc_q.size() >= 3) begin
      check("blk_first_hs", hs_cyc_q[0], p + 65);
      check("blk_interval1", hs_cyc_q[1] - hs_cyc_q[0], 65);
      check("blk_interval2", hs_cyc_q[2] - hs_cyc_q[1], 65);
    end

    // ---------------- held valid across BLOCK -> NORMAL
    ready_in_local = 1'b0;
    push_flit(64'h1111_2222_3333_4444);
    push_flit(64'h5555_6666_7777_8888);
    cnt = 0;
    while (!valid_out_local && cnt < 100) begin
      idle(1);
      cnt++;
    end
    check("hold_valid_rose", valid_out_local, 1'b1);
    check("hold_head", flit_out_local, 64'h1111_2222_3333_4444);
    predicted_congestion_milli = 16'd200;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      check("hold_valid_cycle", valid_out_local, 1'b1);
      check("hold_data_cycle", flit_out_local, 64'h1111_2222_3333_4444);
    end
    check("hold_state_normal", throttle_state, 2'd0);
    ready_in_local = 1'b1;
    idle(4);
    check("hold_sb_empty", exp_q.size(), 0);

    // ---------------- full FIFO and pop with concurrent tile valid
    ready_in_local = 1'b0;
    for (int i = 0; i < 4; i++) push_flit(64'hF0F0_0000_0000_0000 + 64'(i));
    check("full_tile_ready", tile_ready_out, 1'b0);
    ready_in_local = 1'b1;
    tile_cycle(1'b1, 64'hDEAD_DEAD_DEAD_DEAD, acc);
    check("full_push_blocked", acc, 1'b0);
    check("full_after_pop_ready", tile_ready_out, 1'b1);
    ready_in_local = 1'b0;
    idle(1);

    // ---------------- async reset mid-burst
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_valid", valid_out_local, 1'b0);
    check("arst_tile_ready", tile_ready_out, 1'b1);
    check("arst_flit", flit_out_local, 64'd0);
    check("arst_state", throttle_state, 2'd0);
    check("arst_injected", flits_injected_count, 32'd0);
    check("arst_throttled", throttled_cycles_count, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    ready_in_local = 1'b1;
    idle(1);
    push_flit(64'h0123_4567_89AB_CDEF);
    idle(3);
    check("post_rst_injected", flits_injected_count, 32'd1);
    check("post_rst_sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
